// File: rtl/ltl_report_sequencer_pkg.sv
// Shared types and default sizing for the LTL report sequencer and its entry FIFO.
package ltl_report_sequencer_pkg;

  localparam int NUM_REPORTS_DEF = 40;
  localparam int ID_W_DEF        = 6;
  localparam int OFF_W_DEF       = 32;
  localparam int DEPTH_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [NUM_REPORTS_DEF-1:0] vec;
    logic [OFF_W_DEF-1:0]       off;
  } rpt_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous entry FIFO; simultaneous push and pop is legal at any occupancy.
module ltl_report_fifo
  import ltl_report_sequencer_pkg::*;
#(
  parameter int WIDTH = NUM_REPORTS_DEF + OFF_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ltl_report_sequencer.sv
// Sequences one LTL automata stage per session and serializes its non-zero report vectors.
// IDLE: wait for start | RST: stage reset, clear offset | STREAM: feed symbols | DRAIN: flush reports
module ltl_report_sequencer
  import ltl_report_sequencer_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int OFF_W       = OFF_W_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_symbol,
  input  logic                   in_last,
  output logic                   stage_run,
  output logic                   stage_reset,
  output logic [7:0]             stage_symbols,
  input  logic [NUM_REPORTS-1:0] rpt_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic [OFF_W-1:0]       rpt_offset,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [NUM_REPORTS-1:0] vec;
    logic [OFF_W-1:0]       off;
  } entry_t;

  seq_state_t state, state_nxt;

  logic                   accept;
  logic                   inflight;
  logic                   drained;
  logic                   hs;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [OW-1:0]          occupancy;
  logic [OFF_W-1:0]       off_cnt;
  logic [OFF_W-1:0]       cap_off;
  logic [OFF_W-1:0]       work_off;
  logic [NUM_REPORTS-1:0] work_vec;
  logic [NUM_REPORTS-1:0] rest_vec;
  entry_t                 push_entry;
  entry_t                 head;

  // A symbol in flight still owes one FIFO slot, so it counts toward occupancy.
  assign occupancy = {1'b0, fifo_count} + OW'(inflight);
  assign accept    = stage_run;
  assign drained   = !inflight && fifo_empty && !rpt_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RST;
      RST:     state_nxt = STREAM;
      STREAM:  if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    stage_run     = 1'b0;
    stage_reset   = 1'b0;
    stage_symbols = '0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      RST:    stage_reset = 1'b1;
      STREAM: begin
        in_ready      = (occupancy <= OW'(DEPTH - 2)) && !fifo_full;
        stage_run     = in_valid && in_ready;
        stage_symbols = stage_run ? in_symbol : 8'h00;
      end
      DRAIN:  done = drained;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_cnt  <= '0;
      cap_off  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) cap_off <= off_cnt;
      if (state == RST)  off_cnt <= '0;
      else if (accept)   off_cnt <= off_cnt + OFF_W'(1);
    end
  end

  assign fifo_push  = inflight && (rpt_in != '0);
  assign push_entry = '{vec: rpt_in, off: cap_off};

  ltl_report_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clearing the lowest set bit is vec & (vec-1); the next entry loads as soon as nothing remains.
  assign rpt_valid = (work_vec != '0);
  assign hs        = rpt_valid && rpt_ready;
  assign rest_vec  = hs ? (work_vec & (work_vec - NUM_REPORTS'(1))) : work_vec;
  assign fifo_pop  = (rest_vec == '0) && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_vec <= '0;
      work_off <= '0;
    end else if (fifo_pop) begin
      work_vec <= head.vec;
      work_off <= head.off;
    end else begin
      work_vec <= rest_vec;
    end
  end

  always_comb begin
    rpt_id = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
      if (work_vec[i]) rpt_id = ID_W'(i);
    end
  end

  assign rpt_offset = work_off;

endmodule

// File: tb/tb_ltl_report_sequencer.sv
// Randomized bench for ltl_report_sequencer: a 32-bit and a 4-bit offset instance share stimulus,
// and report events are compared with a per-symbol expansion of the applied report vectors.
module tb_ltl_report_sequencer;

  localparam int NR    = 40;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last, rpt_ready;
  logic [7:0]    in_symbol;
  logic [NR-1:0] rpt_in;

  logic          in_ready, stage_run, stage_reset, rpt_valid, busy, done;
  logic [7:0]    stage_symbols;
  logic [5:0]    rpt_id;
  logic [31:0]   rpt_offset;

  logic          in_ready_w, stage_run_w, stage_reset_w, rpt_valid_w, busy_w, done_w;
  logic [7:0]    stage_symbols_w;
  logic [5:0]    rpt_id_w;
  logic [3:0]    rpt_offset_w;

  int errors = 0;
  int checks = 0;

  logic [NR-1:0] plan[$];
  logic [NR-1:0] acc_vecs[$];
  logic [NR-1:0] next_rpt = '0;
  int            ev_id[$];
  int            ev_cyc[$];
  logic [31:0]   ev_off[$];
  logic [3:0]    ev_off_w[$];
  int            exp_id[$];
  int            exp_off[$];

  int cyc = 0;
  int done_cnt = 0, srst_cnt = 0, valid_cnt = 0, mon_err = 0, stab_err = 0, done_cyc = 0;
  int ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_id = '0;
  logic [31:0] prev_off = '0;

  ltl_report_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_symbol(in_symbol), .in_last(in_last), .stage_run(stage_run), .stage_reset(stage_reset),
    .stage_symbols(stage_symbols), .rpt_in(rpt_in), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id), .rpt_offset(rpt_offset), .busy(busy), .done(done)
  );

  ltl_report_sequencer #(.OFF_W(4)) dut_w (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_symbol(in_symbol), .in_last(in_last), .stage_run(stage_run_w), .stage_reset(stage_reset_w),
    .stage_symbols(stage_symbols_w), .rpt_in(rpt_in), .rpt_valid(rpt_valid_w), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id_w), .rpt_offset(rpt_offset_w), .busy(busy_w), .done(done_w)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // The stage answers one cycle after each accept with the planned vector.
  always @(posedge clk) begin
    #1;
    rpt_in   = next_rpt;
    next_rpt = '0;
    case (ready_mode)
      0:       rpt_ready = 1'b0;
      1:       rpt_ready = 1'b1;
      default: rpt_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    logic [NR-1:0] v;
    cyc++;
    if (reset) begin
      if (in_valid && in_ready) begin
        v = (plan.size() > 0) ? plan.pop_front() : '0;
        acc_vecs.push_back(v);
        next_rpt = v;
        if (stage_run !== 1'b1 || stage_symbols !== in_symbol) mon_err++;
      end else if (stage_run !== 1'b0) mon_err++;
      if (in_ready_w !== in_ready || rpt_valid_w !== rpt_valid || done_w !== done ||
          rpt_id_w !== rpt_id || busy_w !== busy) mon_err++;
      if (rpt_valid && rpt_ready) begin
        ev_id.push_back(int'(rpt_id));
        ev_off.push_back(rpt_offset);
        ev_off_w.push_back(rpt_offset_w);
        ev_cyc.push_back(cyc);
      end
      if (prev_stall && (rpt_valid !== 1'b1 || rpt_id !== prev_id || rpt_offset !== prev_off)) stab_err++;
      prev_stall = rpt_valid && !rpt_ready;
      prev_id    = rpt_id;
      prev_off   = rpt_offset;
      if (rpt_valid) valid_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (stage_reset) srst_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    plan.delete(); acc_vecs.delete();
    ev_id.delete(); ev_off.delete(); ev_off_w.delete(); ev_cyc.delete();
    done_cnt = 0; srst_cnt = 0; valid_cnt = 0; mon_err = 0; stab_err = 0; done_cyc = 0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  task automatic send(input logic [7:0] sym, input logic last, input int gap);
    logic got = 1'b0;
    int   n = 0;
    in_valid = 1'b0;
    tick(gap);
    in_valid = 1'b1; in_symbol = sym; in_last = last;
    while (!got && n < 300) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_accept: symbol %h not accepted within %0d cycles, expected accept", sym, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(1); n++; end
    tick(3);
  endtask

  // Reference: every accepted symbol k contributes one event per set bit, ascending, at offset k.
  task automatic build_model();
    exp_id.delete(); exp_off.delete();
    foreach (acc_vecs[k])
      for (int b = 0; b < NR; b++)
        if (acc_vecs[k][b]) begin exp_id.push_back(b); exp_off.push_back(k); end
  endtask

  function automatic logic [NR-1:0] rand_vec(input logic nonzero, input logic sparse);
    logic [63:0] r, s;
    logic [NR-1:0] v;
    r = {$urandom, $urandom};
    s = {$urandom, $urandom};
    v = sparse ? NR'(r & s) : NR'(r);
    if (nonzero) v[$urandom_range(0, NR-1)] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, stage_run, stage_reset, rpt_valid, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b run=%b srst=%b valid=%b busy=%b done=%b, expected all 0",
               in_ready, stage_run, stage_reset, rpt_valid, busy, done);
    end
    checks++;
    if (stage_symbols !== 8'h00 || rpt_id !== 6'd0 || rpt_offset !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: sym=%h id=%0d off=%0d, expected 0 0 0", stage_symbols, rpt_id, rpt_offset);
    end
    checks++;
    if (rpt_offset_w !== 4'd0 || busy_w !== 1'b0 || in_ready_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_narrow: off=%0d busy=%b ready=%b, expected 0", rpt_offset_w, busy_w, in_ready_w);
    end
    tick(1);
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ready=%b, expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [NR-1:0] v;
    ready_mode = 1; tick(2); clear_obs();
    v = '0; plan.push_back(v); v[5] = 1'b1; plan.push_back(v); plan.push_back('0);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (stage_reset !== 1'b0) begin
      errors++; $display("FAIL basic_srst_c: stage_reset=%b in start cycle, expected 0", stage_reset);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (stage_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_srst_c1: srst=%b ready=%b busy=%b, expected 1 0 1", stage_reset, in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || stage_reset !== 1'b0) begin
      errors++; $display("FAIL basic_ready_c2: ready=%b srst=%b, expected 1 0", in_ready, stage_reset);
    end
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b1, 0);
    wait_done(200);
    checks++;
    if (ev_id.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d events, expected 1", ev_id.size());
    end else begin
      checks++;
      if (ev_id[0] != 5 || ev_off[0] !== 32'd1 || ev_off_w[0] !== 4'd1) begin
        errors++;
        $display("FAIL basic_event: got id=%0d off=%0d offw=%0d, expected id=5 off=1", ev_id[0], ev_off[0], ev_off_w[0]);
      end
    end
    checks++;
    if (done_cnt != 1 || srst_cnt != 1) begin
      errors++; $display("FAIL basic_pulses: done=%0d srst=%0d, expected 1 1", done_cnt, srst_cnt);
    end
    checks++;
    if (mon_err != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_stage_io: errors=%0d busy=%b, expected 0 0", mon_err, busy);
    end
  endtask

  task automatic test_multibit();
    logic [NR-1:0] v;
    ready_mode = 1; tick(2); clear_obs();
    v = '0; v[0] = 1'b1; v[7] = 1'b1; v[39] = 1'b1;
    plan.push_back(v);
    begin_session();
    send(8'($urandom), 1'b1, 0);
    wait_done(200);
    checks++;
    if (ev_id.size() != 3) begin
      errors++; $display("FAIL multi_count: got %0d events, expected 3", ev_id.size());
    end else begin
      checks++;
      if (ev_id[0] != 0 || ev_id[1] != 7 || ev_id[2] != 39) begin
        errors++; $display("FAIL multi_ids: got %0d %0d %0d, expected 0 7 39", ev_id[0], ev_id[1], ev_id[2]);
      end
      checks++;
      if (ev_off[0] !== 32'd0 || ev_off[1] !== 32'd0 || ev_off[2] !== 32'd0) begin
        errors++; $display("FAIL multi_offs: got %0d %0d %0d, expected 0 0 0", ev_off[0], ev_off[1], ev_off[2]);
      end
      checks++;
      if (ev_cyc[1] != ev_cyc[0] + 1 || ev_cyc[2] != ev_cyc[1] + 1) begin
        errors++; $display("FAIL multi_spacing: cycles %0d %0d %0d, expected consecutive", ev_cyc[0], ev_cyc[1], ev_cyc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 0; tick(2); clear_obs();
    for (int i = 0; i < 12; i++) plan.push_back(rand_vec(1'b1, 1'b1));
    begin_session();
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_symbol = 8'($urandom);
      tick(1);
    end
    checks++;
    if (acc_vecs.size() != DEPTH || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: accepted=%0d ready=%b, expected %0d 0", acc_vecs.size(), in_ready, DEPTH);
    end
    in_valid = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 4; i++) send(8'($urandom), (i == 3), $urandom_range(0, 1));
    wait_done(1000);
    build_model();
    checks++;
    if (ev_id.size() != exp_id.size()) begin
      errors++; $display("FAIL bp_count: got %0d events, expected %0d", ev_id.size(), exp_id.size());
    end else foreach (exp_id[i]) begin
      checks++;
      if (ev_id[i] != exp_id[i] || ev_off[i] !== 32'(exp_off[i]) || ev_off_w[i] !== 4'(exp_off[i])) begin
        errors++;
        $display("FAIL bp_event[%0d]: got id=%0d off=%0d offw=%0d, expected id=%0d off=%0d",
                 i, ev_id[i], ev_off[i], ev_off_w[i], exp_id[i], exp_off[i]);
      end
      if (i > 0) begin
        checks++;
        if (ev_off[i] < ev_off[i-1]) begin
          errors++; $display("FAIL bp_order[%0d]: offset %0d after %0d, expected non-decreasing", i, ev_off[i], ev_off[i-1]);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || stab_err != 0 || mon_err != 0) begin
      errors++; $display("FAIL bp_misc: done=%0d stab=%0d mon=%0d, expected 1 0 0", done_cnt, stab_err, mon_err);
    end
  endtask

  task automatic test_start_drain();
    ready_mode = 0; tick(2); clear_obs();
    for (int i = 0; i < 5; i++) plan.push_back(rand_vec(1'b1, 1'b1));
    begin_session();
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 0);
    start = 1'b1; tick(1); start = 1'b0;
    send(8'($urandom), 1'b1, 0);
    tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    checks++;
    if (done_cnt != 0 || busy !== 1'b1 || srst_cnt != 1) begin
      errors++;
      $display("FAIL drain_hold: done=%0d busy=%b srst=%0d, expected 0 1 1", done_cnt, busy, srst_cnt);
    end
    ready_mode = 1;
    wait_done(1000);
    checks++;
    if (done_cnt != 1 || srst_cnt != 1) begin
      errors++; $display("FAIL drain_pulses: done=%0d srst=%0d, expected 1 1", done_cnt, srst_cnt);
    end
    build_model();
    checks++;
    if (ev_id.size() != exp_id.size() || ev_id.size() == 0) begin
      errors++; $display("FAIL drain_count: got %0d events, expected %0d", ev_id.size(), exp_id.size());
    end else begin
      checks++;
      if (done_cyc != ev_cyc[ev_cyc.size()-1] + 1) begin
        errors++;
        $display("FAIL drain_done_time: done at %0d, last handshake %0d, expected one cycle later", done_cyc, ev_cyc[ev_cyc.size()-1]);
      end
      foreach (exp_id[i]) begin
        checks++;
        if (ev_id[i] != exp_id[i] || ev_off[i] !== 32'(exp_off[i])) begin
          errors++;
          $display("FAIL drain_event[%0d]: got id=%0d off=%0d, expected id=%0d off=%0d", i, ev_id[i], ev_off[i], exp_id[i], exp_off[i]);
        end
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL drain_stable: %0d unstable stalled cycles, expected 0", stab_err);
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] v;
    ready_mode = 1; tick(2); clear_obs();
    v = '0; v[2] = 1'b1;
    for (int i = 0; i < 18; i++) plan.push_back(v);
    begin_session();
    for (int i = 0; i < 18; i++) send(8'($urandom), (i == 17), $urandom_range(0, 1));
    wait_done(500);
    checks++;
    if (ev_id.size() != 18) begin
      errors++; $display("FAIL wrap_count: got %0d events, expected 18", ev_id.size());
    end else foreach (ev_id[i]) begin
      checks++;
      if (ev_id[i] != 2 || ev_off_w[i] !== 4'(i % 16) || ev_off[i] !== 32'(i)) begin
        errors++;
        $display("FAIL wrap_event[%0d]: got id=%0d offw=%0d off=%0d, expected id=2 offw=%0d off=%0d",
                 i, ev_id[i], ev_off_w[i], ev_off[i], i % 16, i);
      end
    end
  endtask

  task automatic test_random();
    int nsym;
    for (int s = 0; s < 4; s++) begin
      ready_mode = 2; tick(2); clear_obs();
      nsym = $urandom_range(5, 24);
      for (int i = 0; i < nsym; i++) plan.push_back(($urandom_range(0, 2) == 0) ? '0 : rand_vec(1'b0, 1'b1));
      begin_session();
      for (int i = 0; i < nsym; i++) send(8'($urandom), (i == nsym - 1), $urandom_range(0, 2));
      wait_done(4000);
      build_model();
      checks++;
      if (ev_id.size() != exp_id.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d events, expected %0d", s, ev_id.size(), exp_id.size());
      end else foreach (exp_id[i]) begin
        checks++;
        if (ev_id[i] != exp_id[i] || ev_off[i] !== 32'(exp_off[i]) || ev_off_w[i] !== 4'(exp_off[i])) begin
          errors++;
          $display("FAIL rand%0d_event[%0d]: got id=%0d off=%0d offw=%0d, expected id=%0d off=%0d",
                   s, i, ev_id[i], ev_off[i], ev_off_w[i], exp_id[i], exp_off[i]);
        end
      end
      checks++;
      if (done_cnt != 1 || srst_cnt != 1 || stab_err != 0 || mon_err != 0) begin
        errors++;
        $display("FAIL rand%0d_misc: done=%0d srst=%0d stab=%0d mon=%0d, expected 1 1 0 0",
                 s, done_cnt, srst_cnt, stab_err, mon_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    ready_mode = 0; tick(2); clear_obs();
    for (int i = 0; i < 4; i++) plan.push_back(rand_vec(1'b1, 1'b0));
    begin_session();
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 0);
    tick(3);
    checks++;
    if (rpt_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_pending: valid=%b busy=%b, expected 1 1", rpt_valid, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, stage_run, stage_reset, rpt_valid, busy, done} !== 6'b0 ||
        stage_symbols !== 8'h00 || rpt_id !== 6'd0 || rpt_offset !== 32'd0) begin
      errors++;
      $display("FAIL rmid_outputs: ready=%b run=%b srst=%b valid=%b busy=%b done=%b id=%0d off=%0d, expected all 0",
               in_ready, stage_run, stage_reset, rpt_valid, busy, done, rpt_id, rpt_offset);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ready_mode = 1;
    valid_cnt = 0;
    tick(12);
    checks++;
    if (valid_cnt != 0 || busy !== 1'b0 || done_cnt != 0) begin
      errors++; $display("FAIL rmid_after: valid cycles=%0d busy=%b done=%0d, expected 0 0 0", valid_cnt, busy, done_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_symbol = 8'h00; rpt_in = '0; rpt_ready = 1'b0;
    test_reset();
    test_basic();
    test_multibit();
    test_backpressure();
    test_start_drain();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
